// File: rtl/score_sequencer_pkg.sv
// Shared widths, state encoding, ROM entry helpers and the song table
// used by the score sequencer and its ROM.
package score_sequencer_pkg;

  localparam int NOTE_W  = 10;
  localparam int IDX_W   = 8;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = DUR_W + NOTE_W;

  localparam int TICK_DIV_DEFAULT  = 25_000_000;
  localparam int GAP_TICKS_DEFAULT = 2_500_000;

  localparam logic [NOTE_W-1:0] REST    = '0;
  localparam logic [DUR_W-1:0]  END_DUR = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    DONE
  } seq_state_t;

  function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] entry);
    return entry[NOTE_W-1:0];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1:NOTE_W];
  endfunction

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [DUR_W-1:0]  dur,
                                                   input logic [NOTE_W-1:0] note);
    return {dur, note};
  endfunction

  // Song file contents; any index past the listed entries reads as an end marker.
  function automatic logic [ENTRY_W-1:0] song_entry(input logic [IDX_W-1:0] idx);
    logic [ENTRY_W-1:0] entry;
    case (idx)
      8'd0:    entry = make_entry(4'd2, 10'h021);
      8'd1:    entry = make_entry(4'd1, REST);
      8'd2:    entry = make_entry(4'd3, 10'h105);
      default: entry = make_entry(END_DUR, REST);
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/score_sequencer_rom.sv
// Synchronous song ROM: the entry at i_addr appears on o_data one clock later.
module score_rom
  import score_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   i_addr,
  output logic [ENTRY_W-1:0] o_data
);

  logic [ENTRY_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else begin
      r_data <= song_entry(i_addr);
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/score_sequencer.sv
// Score reader: presents the study-mode note at the requested index, or walks
// the song in auto-play with per-note duration timing and inter-note gaps.
module score_sequencer
  import score_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int GAP_TICKS = GAP_TICKS_DEFAULT
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mode,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic [IDX_W-1:0]  i_study_index,
  output logic [NOTE_W-1:0] o_note_out,
  output logic              o_note_valid,
  output logic [IDX_W-1:0]  o_cur_index,
  output logic              o_beat_pulse,
  output logic              o_song_end
);

  localparam logic [31:0]      TICK_LEN = 32'(TICK_DIV);
  localparam logic [31:0]      GAP_LOAD = 32'(GAP_TICKS) - 32'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  seq_state_t        r_state;
  logic [31:0]       r_timer;
  logic [IDX_W-1:0]  r_cur_index;
  logic [IDX_W-1:0]  r_addr_d;
  logic [NOTE_W-1:0] r_note_out;
  logic              r_note_valid;
  logic              r_beat_pulse;
  logic              r_song_end;

  logic [IDX_W-1:0]   w_rom_addr;
  logic [ENTRY_W-1:0] w_rom_data;
  logic [NOTE_W-1:0]  w_rom_note;
  logic [DUR_W-1:0]   w_rom_dur;
  logic               w_rom_end;
  logic               w_timer_zero;
  logic               w_gap_end;
  logic [31:0]        w_play_load;

  assign w_rom_note   = entry_note(w_rom_data);
  assign w_rom_dur    = entry_dur(w_rom_data);
  assign w_rom_end    = (w_rom_dur == END_DUR);
  assign w_timer_zero = (r_timer == 32'd0);
  assign w_gap_end    = (r_state == GAP) && w_timer_zero && !i_pause;
  assign w_play_load  = 32'(w_rom_dur) * TICK_LEN - 32'd1;

  // The auto-play address already points at the next entry on the edge that
  // enters FETCH, so the ROM data is ready during the single FETCH cycle.
  always_comb begin
    w_rom_addr = r_cur_index;
    if (!i_mode) begin
      w_rom_addr = i_study_index;
    end else if (i_start) begin
      w_rom_addr = '0;
    end else if (w_gap_end) begin
      w_rom_addr = r_cur_index + IDX_W'(1);
    end
  end

  score_rom u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  // Tracks which index the ROM data currently belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_d <= '0;
    end else begin
      r_addr_d <= w_rom_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_cur_index  <= '0;
      r_note_out   <= '0;
      r_note_valid <= 1'b0;
      r_beat_pulse <= 1'b0;
      r_song_end   <= 1'b0;
    end else begin
      r_beat_pulse <= 1'b0;
      if (!i_mode) begin
        r_state      <= IDLE;
        r_timer      <= '0;
        r_cur_index  <= r_addr_d;
        r_note_out   <= w_rom_end ? REST : w_rom_note;
        r_note_valid <= !w_rom_end;
        r_song_end   <= w_rom_end;
      end else if (i_start) begin
        r_state      <= FETCH;
        r_timer      <= '0;
        r_cur_index  <= '0;
        r_note_out   <= REST;
        r_note_valid <= 1'b0;
        r_song_end   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_timer      <= '0;
            r_cur_index  <= '0;
            r_note_out   <= REST;
            r_note_valid <= 1'b0;
            r_song_end   <= 1'b0;
          end
          FETCH: begin
            if (!i_pause) begin
              if (w_rom_end) begin
                r_state      <= DONE;
                r_note_out   <= REST;
                r_note_valid <= 1'b0;
                r_song_end   <= 1'b1;
              end else begin
                r_state      <= PLAY;
                r_timer      <= w_play_load;
                r_note_out   <= w_rom_note;
                r_note_valid <= 1'b1;
                r_beat_pulse <= 1'b1;
              end
            end
          end
          PLAY: begin
            if (!i_pause) begin
              if (w_timer_zero) begin
                r_state    <= GAP;
                r_timer    <= GAP_LOAD;
                r_note_out <= REST;
              end else begin
                r_timer <= r_timer - 32'd1;
              end
            end
          end
          GAP: begin
            if (!i_pause) begin
              if (!w_timer_zero) begin
                r_timer <= r_timer - 32'd1;
              end else if (r_cur_index == LAST_IDX) begin
                // Running off the top of the index space ends the song rather than wrapping.
                r_state      <= DONE;
                r_note_valid <= 1'b0;
                r_song_end   <= 1'b1;
              end else begin
                r_state     <= FETCH;
                r_cur_index <= r_cur_index + IDX_W'(1);
              end
            end
          end
          DONE: begin
            r_note_out   <= REST;
            r_note_valid <= 1'b0;
            r_song_end   <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_note_out   = r_note_out;
  assign o_note_valid = r_note_valid;
  assign o_cur_index  = r_cur_index;
  assign o_beat_pulse = r_beat_pulse;
  assign o_song_end   = r_song_end;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer: randomized study indices, pause and
// restart points, checked cycle by cycle against a song-trace reference model.
module tb_score_sequencer;

  localparam int TICK = 4;
  localparam int GAPT = 2;

  typedef struct packed {
    logic [9:0] note;
    logic       valid;
    logic       beat;
    logic       send;
    logic [7:0] idx;
  } obs_t;

  logic       clk           = 1'b0;
  logic       rst           = 1'b0;
  logic       i_mode        = 1'b0;
  logic       i_start       = 1'b0;
  logic       i_pause       = 1'b0;
  logic [7:0] i_study_index = 8'd0;
  logic [9:0] o_note_out;
  logic       o_note_valid;
  logic [7:0] o_cur_index;
  logic       o_beat_pulse;
  logic       o_song_end;

  int checks   = 0;
  int failures = 0;

  int         song_dur  [4] = '{2, 1, 3, 0};
  logic [9:0] song_note [4] = '{10'h021, 10'h000, 10'h105, 10'h000};

  obs_t exp_q[$];

  always #5 clk = ~clk;

  score_sequencer #(
    .TICK_DIV  (TICK),
    .GAP_TICKS (GAPT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mode        (i_mode),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_study_index (i_study_index),
    .o_note_out    (o_note_out),
    .o_note_valid  (o_note_valid),
    .o_cur_index   (o_cur_index),
    .o_beat_pulse  (o_beat_pulse),
    .o_song_end    (o_song_end)
  );

  function automatic obs_t mk(input logic [9:0] note, input logic valid, input logic beat,
                              input logic send, input int idx);
    obs_t e;
    e.note  = note;
    e.valid = valid;
    e.beat  = beat;
    e.send  = send;
    e.idx   = 8'(idx);
    return e;
  endfunction

  function automatic obs_t observe();
    return mk(o_note_out, o_note_valid, o_beat_pulse, o_song_end, int'(o_cur_index));
  endfunction

  // Study mode shows the entry at the index, or an end flag past the last note.
  function automatic obs_t study_expect(input int idx);
    if (idx < 4 && song_dur[idx] != 0) return mk(song_note[idx], 1'b1, 1'b0, 1'b0, idx);
    return mk(10'h000, 1'b0, 1'b0, 1'b1, idx);
  endfunction

  // Per-cycle auto-play trace seen after each clock edge, starting with the
  // edge that samples start: one fetch cycle, dur*TICK note cycles, GAPT
  // silent cycles, then a fetch of the next index, ending in song_end.
  task automatic model_song(input int pause_idx, input int pause_len);
    int idx;
    int n;
    exp_q.delete();
    idx = 0;
    exp_q.push_back(mk(10'h000, 1'b0, 1'b0, 1'b0, 0));
    while (idx < 4 && song_dur[idx] != 0) begin
      n = song_dur[idx] * TICK + ((idx == pause_idx) ? pause_len : 0);
      for (int k = 0; k < n; k++) exp_q.push_back(mk(song_note[idx], 1'b1, k == 0, 1'b0, idx));
      for (int k = 0; k < GAPT; k++) exp_q.push_back(mk(10'h000, 1'b1, 1'b0, 1'b0, idx));
      idx++;
      exp_q.push_back(mk(10'h000, 1'b1, 1'b0, 1'b0, idx));
    end
    repeat (2) exp_q.push_back(mk(10'h000, 1'b0, 1'b0, 1'b1, idx));
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t zero;
    int   k;
    zero = mk(10'h000, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== zero) begin
      failures++;
      $display("[TB] FAIL reset_poweron: got %h expected %h", got, zero);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_song(-1, 0);
    k = $urandom_range(2, 7);
    i_mode  = 1'b1;
    i_start = 1'b1;
    for (int j = 0; j <= k; j++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got = observe();
      checks++;
      if (got !== exp_q[j]) begin
        failures++;
        $display("[TB] FAIL reset_preplay cycle %0d: got %h expected %h", j, got, exp_q[j]);
      end
    end
    #2 rst = 1'b0;
    #1;
    got = observe();
    checks++;
    if (got !== zero) begin
      failures++;
      $display("[TB] FAIL reset_async: got %h expected %h", got, zero);
    end
    @(negedge clk) rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      got = observe();
      checks++;
      if (got !== zero) begin
        failures++;
        $display("[TB] FAIL reset_idle: got %h expected %h", got, zero);
      end
    end
  endtask

  task automatic test_study();
    obs_t got;
    int   prev;
    int   cur;
    i_mode        = 1'b0;
    i_start       = 1'b0;
    i_study_index = 8'd0;
    cur           = 0;
    repeat (3) @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== study_expect(0)) begin
      failures++;
      $display("[TB] FAIL study_first: got %h expected %h", got, study_expect(0));
    end
    for (int n = 0; n < 12; n++) begin
      prev = cur;
      if (n == 0) cur = 2;
      else if (n == 1) cur = 3;
      else cur = $urandom_range(0, 3);
      i_study_index = 8'(cur);
      i_start       = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got = observe();
      checks++;
      if (got !== study_expect(prev)) begin
        failures++;
        $display("[TB] FAIL study_hold step %0d: got %h expected %h", n, got, study_expect(prev));
      end
      @(posedge clk);
      #1;
      got = observe();
      checks++;
      if (got !== study_expect(cur)) begin
        failures++;
        $display("[TB] FAIL study_new step %0d: got %h expected %h", n, got, study_expect(cur));
      end
    end
  endtask

  task automatic test_autoplay();
    obs_t got;
    model_song(-1, 0);
    i_mode  = 1'b1;
    i_pause = 1'b0;
    i_start = 1'b1;
    foreach (exp_q[j]) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got = observe();
      checks++;
      if (got !== exp_q[j]) begin
        failures++;
        $display("[TB] FAIL autoplay cycle %0d: got %h expected %h", j, got, exp_q[j]);
      end
    end
  endtask

  task automatic test_pause();
    obs_t got;
    int   len;
    int   p2;
    int   s;
    len = $urandom_range(1, 7);
    model_song(2, len);
    p2 = 0;
    foreach (exp_q[j]) if (exp_q[j].beat && exp_q[j].idx == 8'd2) p2 = j;
    s = p2 + 1 + $urandom_range(0, 12 - len);
    i_mode  = 1'b1;
    i_pause = 1'b0;
    i_start = 1'b1;
    foreach (exp_q[j]) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got = observe();
      checks++;
      if (got !== exp_q[j]) begin
        failures++;
        $display("[TB] FAIL pause cycle %0d (len %0d): got %h expected %h", j, len, got, exp_q[j]);
      end
      i_pause = (j + 1 >= s) && (j + 1 < s + len);
    end
    i_pause = 1'b0;
  endtask

  task automatic test_restart();
    obs_t got;
    int   q;
    int   r;
    model_song(-1, 0);
    q = 0;
    foreach (exp_q[j]) if (exp_q[j].beat && exp_q[j].idx == 8'd1) q = j;
    q = q + song_dur[1] * TICK;
    r = q + 1 + $urandom_range(0, GAPT - 1);
    i_mode  = 1'b1;
    i_start = 1'b1;
    for (int j = 0; j < r; j++) begin
      @(posedge clk);
      #1;
      i_start = (j == r - 1);
      got = observe();
      checks++;
      if (got !== exp_q[j]) begin
        failures++;
        $display("[TB] FAIL restart_pre cycle %0d: got %h expected %h", j, got, exp_q[j]);
      end
    end
    foreach (exp_q[j]) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got = observe();
      checks++;
      if (got !== exp_q[j]) begin
        failures++;
        $display("[TB] FAIL restart_post cycle %0d: got %h expected %h", j, got, exp_q[j]);
      end
    end
  endtask

  task automatic test_mode_change();
    obs_t got;
    int   sidx;
    int   m;
    sidx          = $urandom_range(0, 3);
    i_study_index = 8'(sidx);
    m             = $urandom_range(1, 6);
    model_song(-1, 0);
    i_mode  = 1'b1;
    i_start = 1'b1;
    for (int j = 0; j <= m; j++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got = observe();
      checks++;
      if (got !== exp_q[j]) begin
        failures++;
        $display("[TB] FAIL mode_preplay cycle %0d: got %h expected %h", j, got, exp_q[j]);
      end
    end
    i_mode = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_beat_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mode_beat: got %b expected 0", o_beat_pulse);
    end
    @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== study_expect(sidx)) begin
      failures++;
      $display("[TB] FAIL mode_study: got %h expected %h", got, study_expect(sidx));
    end
    i_mode = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      got = observe();
      checks++;
      if (got !== mk(10'h000, 1'b0, 1'b0, 1'b0, 0)) begin
        failures++;
        $display("[TB] FAIL mode_idle: got %h expected %h", got, mk(10'h000, 1'b0, 1'b0, 1'b0, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_study();
    test_autoplay();
    test_pause();
    test_restart();
    test_mode_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
